mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_SIZE, default 32, SHALL set the data word width.
REQ-002 Parameter ADDRESS_SIZE, default 16, SHALL set the word-address width.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-004 reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 f_req  in  1  SHALL be the instruction-fetch read request.
REQ-006 f_addr  in  ADDRESS_SIZE  SHALL be the fetch word address.
REQ-007 f_ack  out  1  SHALL be a one-cycle fetch completion pulse.
REQ-008 f_rdata  out  DATA_SIZE  SHALL be the fetched word.
REQ-009 d_req  in  1  SHALL be the data (LDR/STR) request.
REQ-010 d_rw  in  1  SHALL select the data operation: 1 = read (LDR), 0 = write (STR).
REQ-011 d_addr  in  ADDRESS_SIZE  SHALL be the data word address.
REQ-012 d_wdata  in  DATA_SIZE  SHALL be the store data.
REQ-013 d_ack  out  1  SHALL be a one-cycle data completion pulse.
REQ-014 d_rdata  out  DATA_SIZE  SHALL be the loaded word.
REQ-015 ram_enable  out  1  SHALL be the RAM enable.
REQ-016 ram_read_write  out  1  SHALL be the RAM direction: 1 = read, 0 = write.
REQ-017 ram_address  out  ADDRESS_SIZE  SHALL be the RAM address.
REQ-018 ram_wdata  out  DATA_SIZE  SHALL be the RAM write data.
REQ-019 ram_rdata  in  DATA_SIZE  SHALL be the RAM read data.

Function
REQ-020 The state machine SHALL have four states: IDLE, F_ACC, D_ACC, RESP.
REQ-021 Requests SHALL be sampled only in IDLE.
- f_req only: go to F_ACC.
- d_req only: go to D_ACC.
- Neither: stay in IDLE.
REQ-022 On the IDLE->ACC edge, the arbiter SHALL register the winner's address, direction and write data (fetch is always read); operands SHALL NOT be re-sampled afterwards.
REQ-023 In F_ACC/D_ACC, for exactly one cycle, the arbiter SHALL drive:
- ram_enable = 1
- ram_read_write = registered direction
- ram_address = registered address
- ram_wdata = registered write data
It SHALL then go to RESP.
REQ-024 Outside F_ACC/D_ACC, ram_enable, ram_read_write, ram_address and ram_wdata SHALL all be 0.
REQ-025 In RESP, for one cycle, the served port's ack SHALL be 1; a read SHALL load ram_rdata into that port's rdata on the ACC->RESP edge. RESP SHALL return to IDLE.
REQ-026 Latency from request sampled in IDLE to ack SHALL be 2 cycles; peak throughput SHALL be one transaction per 3 cycles.
REQ-027 A write ack SHALL leave d_rdata unchanged; each rdata SHALL hold until that port's next read ack.
REQ-028 f_ack and d_ack SHALL never be 1 in the same cycle.
REQ-029 Requesters SHALL hold req and operands stable until ack and deassert req in the cycle after ack; a req high in IDLE after that SHALL be a new request.
REQ-030 Simultaneous f_req and d_req in IDLE SHALL be resolved per REQ-035/REQ-036; the loser's request SHALL remain pending, not be dropped.

Reset
REQ-031 While reset = 1, state SHALL be IDLE and f_ack, d_ack and all ram_* outputs SHALL be 0.
REQ-032 Reset SHALL clear f_rdata and d_rdata to 0 and last_served to fetch.
REQ-033 Reset asserted in D_ACC SHALL force ram_enable to 0 asynchronously; the aborted transaction SHALL produce no ack and SHALL NOT be retried.
REQ-034 After reset deassertion, the first arbitration SHALL occur at the first rising edge in IDLE.

Configuration
REQ-035 With MEM_ARB_ROUND_ROBIN_EN defined:
- Simultaneous requests SHALL be granted to the port not in last_served.
- last_served SHALL update on each grant.
REQ-036 Without MEM_ARB_ROUND_ROBIN_EN, simultaneous requests SHALL always be granted to data (fixed data priority), and no last_served register SHALL exist.

Verification
REQ-037 f_req=1, f_addr=0x0010, ram_rdata=0xDEADBEEF in F_ACC -> ram_enable=1 and ram_address=0x0010 one cycle; f_ack one cycle later with f_rdata=0xDEADBEEF.
REQ-038 d_req=1, d_rw=0, d_addr=0x0100, d_wdata=0x12345678 -> in D_ACC: ram_read_write=0, ram_wdata=0x12345678; d_ack pulse; d_rdata unchanged.
REQ-039 f_req and d_req both held high for 6 cycles:
- Fixed priority: d_ack at cycle 2, then f_ack at cycle 5.
- Round-robin: same order after reset; next tie goes to fetch.
REQ-040 d_req held high continuously with f_req high -> without _EN, fetch starves; with _EN, acks alternate d, f, d, f.
REQ-041 Reset pulsed during D_ACC of a write -> ram_enable drops immediately, no d_ack, state IDLE, rdata outputs 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto a single-port RAM; each transaction is IDLE -> ACC -> RESP.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking (default: fixed data priority).
module mem_arbiter #(
    parameter int unsigned DATA_SIZE    = 32,
    parameter int unsigned ADDRESS_SIZE = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    f_req,
    input  logic [ADDRESS_SIZE-1:0] f_addr,
    output logic                    f_ack,
    output logic [DATA_SIZE-1:0]    f_rdata,
    input  logic                    d_req,
    input  logic                    d_rw,
    input  logic [ADDRESS_SIZE-1:0] d_addr,
    input  logic [DATA_SIZE-1:0]    d_wdata,
    output logic                    d_ack,
    output logic [DATA_SIZE-1:0]    d_rdata,
    output logic                    ram_enable,
    output logic                    ram_read_write,
    output logic [ADDRESS_SIZE-1:0] ram_address,
    output logic [DATA_SIZE-1:0]    ram_wdata,
    input  logic [DATA_SIZE-1:0]    ram_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        F_ACC = 2'd1,
        D_ACC = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    w_grant_f;
    logic                    w_grant_d;

    logic                    r_ram_enable;
    logic                    r_ram_read_write;
    logic [ADDRESS_SIZE-1:0] r_ram_address;
    logic [DATA_SIZE-1:0]    r_ram_wdata;
    logic                    r_f_ack;
    logic                    r_d_ack;
    logic [DATA_SIZE-1:0]    r_f_rdata;
    logic [DATA_SIZE-1:0]    r_d_rdata;

    logic                    w_ram_enable;
    logic                    w_ram_read_write;
    logic [ADDRESS_SIZE-1:0] w_ram_address;
    logic [DATA_SIZE-1:0]    w_ram_wdata;
    logic                    w_f_ack;
    logic                    w_d_ack;
    logic                    w_f_load;
    logic                    w_d_load;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // r_last_d: 1 when data was the most recent grant, 0 when fetch was
    logic r_last_d;

    always_comb begin
        w_grant_d = d_req & (~f_req | ~r_last_d);
        w_grant_f = f_req & ~w_grant_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_d <= 1'b0;
        end else if ((r_state == IDLE) && (w_grant_f || w_grant_d)) begin
            r_last_d <= w_grant_d;
        end
    end
`else
    always_comb begin
        w_grant_d = d_req;
        w_grant_f = f_req & ~d_req;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_next_state = D_ACC;
                end else if (w_grant_f) begin
                    w_next_state = F_ACC;
                end
            end
            F_ACC, D_ACC: w_next_state = RESP;
            default:      w_next_state = IDLE;
        endcase
    end

    // Next values of the registered outputs; the ram_* registers double as the operand latch
    always_comb begin
        w_ram_enable     = 1'b0;
        w_ram_read_write = 1'b0;
        w_ram_address    = '0;
        w_ram_wdata      = '0;
        w_f_ack          = 1'b0;
        w_d_ack          = 1'b0;
        w_f_load         = 1'b0;
        w_d_load         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_ram_enable     = 1'b1;
                    w_ram_read_write = d_rw;
                    w_ram_address    = d_addr;
                    w_ram_wdata      = d_wdata;
                end else if (w_grant_f) begin
                    w_ram_enable     = 1'b1;
                    w_ram_read_write = 1'b1;
                    w_ram_address    = f_addr;
                end
            end
            F_ACC: begin
                w_f_ack  = 1'b1;
                w_f_load = 1'b1;
            end
            D_ACC: begin
                w_d_ack  = 1'b1;
                w_d_load = r_ram_read_write;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ram_enable     <= 1'b0;
            r_ram_read_write <= 1'b0;
            r_ram_address    <= '0;
            r_ram_wdata      <= '0;
            r_f_ack          <= 1'b0;
            r_d_ack          <= 1'b0;
            r_f_rdata        <= '0;
            r_d_rdata        <= '0;
        end else begin
            r_ram_enable     <= w_ram_enable;
            r_ram_read_write <= w_ram_read_write;
            r_ram_address    <= w_ram_address;
            r_ram_wdata      <= w_ram_wdata;
            r_f_ack          <= w_f_ack;
            r_d_ack          <= w_d_ack;
            if (w_f_load) begin
                r_f_rdata <= ram_rdata;
            end
            if (w_d_load) begin
                r_d_rdata <= ram_rdata;
            end
        end
    end

    assign ram_enable     = r_ram_enable;
    assign ram_read_write = r_ram_read_write;
    assign ram_address    = r_ram_address;
    assign ram_wdata      = r_ram_wdata;
    assign f_ack          = r_f_ack;
    assign d_ack          = r_d_ack;
    assign f_rdata        = r_f_rdata;
    assign d_rdata        = r_d_rdata;

endmodule
